// File: rtl/inference_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// inference_ctrl_fsm_pkg
//
// Shared definitions for the inference controller: the state encodings used
// on the state bus (consumed by the datapath and the output serializer), the
// number of states and the derived state-bus width.
//
// The four existing encodings are fixed. Downstream decoders depend on them,
// so a new state must take a new code and leave these unchanged.
// -----------------------------------------------------------------------------
package inference_ctrl_fsm_pkg;

  localparam int NUMBER_OF_STATES = 4;
  localparam int STATE_BIT_WIDTH  = $clog2(NUMBER_OF_STATES);

  typedef enum logic [STATE_BIT_WIDTH-1:0] {
    IDLE                = STATE_BIT_WIDTH'(0),
    RUNNING             = STATE_BIT_WIDTH'(1),
    SENDING             = STATE_BIT_WIDTH'(2),
    PROCESSING_FEW_SHOT = STATE_BIT_WIDTH'(3)
  } state_e;

endpackage : inference_ctrl_fsm_pkg

// File: rtl/inference_ctrl_fsm_sat_counter.sv
// -----------------------------------------------------------------------------
// inference_ctrl_fsm_sat_counter
//
// Up-counter with a synchronous clear. When the count reaches all-ones it
// holds there and does not wrap. If clear and enable are both high in the same
// cycle, clear takes priority.
//
// Ports
//   clk     in   clock
//   rst     in   synchronous active-high reset (count -> 0)
//   clear   in   synchronous clear (count -> 0)
//   enable  in   count up by one this cycle
//   count   out  current count (registered)
// -----------------------------------------------------------------------------
module inference_ctrl_fsm_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  logic at_max;

  assign at_max = (count == {WIDTH{1'b1}});

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_max) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : inference_ctrl_fsm_sat_counter

// File: rtl/inference_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// inference_ctrl_fsm
//
// Top-level processing controller. It sits between the host/SPI command
// decoder and the network datapath. It sequences
// IDLE -> RUNNING -> SENDING / PROCESSING_FEW_SHOT, and it drives the state
// bus that the datapath and the output serializer read.
//
// Beyond the basic sequencing it provides:
//   - an output-word valid/ready handshake that counts beats and flags the
//     last word;
//   - a bounded inference count for continuous mode;
//   - a watchdog timeout on few-shot processing.
//
// Parameters
//   OUT_WORDS_WIDTH    width of the per-inference output word count
//   INFER_COUNT_WIDTH  width of the inference limit and the inference counter
//   TIMEOUT_WIDTH      width of the few-shot watchdog limit and timer
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   continuous_processing      restart after each send
//   classification             classification mode
//   is_output_layer            current layer is the output layer
//   toggle_processing_new      start request (in IDLE) or stop request
//   start_sending              results ready to send
//   skip_sending               finish the inference without sending
//   num_output_words           words to send; latched when start_sending is taken
//   out_ready / out_valid      output word handshake
//   out_last                   current word is the final word of the send
//   start_few_shot_processing  enter few-shot learning
//   done_few_shot_processing   few-shot learning complete
//   few_shot_timeout           watchdog limit in cycles; 0 disables the watchdog
//   num_inferences             continuous-mode inference limit; 0 = unlimited
//   inference_count            completed sends since the last start
//   timed_out                  sticky: the last few-shot phase hit the watchdog
//   state / next_state         registered state / combinational next state
// -----------------------------------------------------------------------------
module inference_ctrl_fsm
  import inference_ctrl_fsm_pkg::*;
#(
  parameter int OUT_WORDS_WIDTH   = 8,
  parameter int INFER_COUNT_WIDTH = 16,
  parameter int TIMEOUT_WIDTH     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         continuous_processing,
  input  logic                         classification,
  input  logic                         is_output_layer,
  input  logic                         toggle_processing_new,
  input  logic                         start_sending,
  input  logic                         skip_sending,
  input  logic [OUT_WORDS_WIDTH-1:0]   num_output_words,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         start_few_shot_processing,
  input  logic                         done_few_shot_processing,
  input  logic [TIMEOUT_WIDTH-1:0]     few_shot_timeout,
  input  logic [INFER_COUNT_WIDTH-1:0] num_inferences,
  output logic [INFER_COUNT_WIDTH-1:0] inference_count,
  output logic                         timed_out,
  output logic [STATE_BIT_WIDTH-1:0]   state,
  output logic [STATE_BIT_WIDTH-1:0]   next_state
);

  state_e                       state_q;
  state_e                       state_d;
  logic [OUT_WORDS_WIDTH-1:0]   remaining;
  logic [OUT_WORDS_WIDTH-1:0]   remaining_d;
  logic                         stop_pending;
  logic [TIMEOUT_WIDTH-1:0]     timer;

  logic                         beat;
  logic                         send_done;
  logic                         want_restart;
  logic                         stop_req;
  logic                         below_limit;
  logic                         watchdog_hit;
  logic                         enter_run;
  logic                         enter_few_shot;
  logic                         in_few_shot;
  logic [INFER_COUNT_WIDTH:0]   count_plus_one;

  assign state      = state_q;
  assign next_state = state_d;

  // ---------------------------------------------------------------------------
  // Handshake and completion decode
  // ---------------------------------------------------------------------------
  // out_valid is always equal to (state_q == SENDING), because both registers
  // are loaded from the same next-state value. The beat can therefore be
  // decoded from state_q directly.
  assign beat      = (state_q == SENDING) & out_ready;
  assign send_done = beat & (remaining == OUT_WORDS_WIDTH'(1));

  // The extra bit prevents a wrap when inference_count is already all-ones.
  assign count_plus_one = {1'b0, inference_count} + (INFER_COUNT_WIDTH + 1)'(1);
  assign below_limit    = (num_inferences == '0) |
                          (count_plus_one < {1'b0, num_inferences});

  assign want_restart = continuous_processing | (~classification & is_output_layer);

  // A stop request that arrives on the final beat itself also counts, so that
  // a toggle during a send is never lost.
  assign stop_req = stop_pending | toggle_processing_new;

  assign in_few_shot  = (state_q == PROCESSING_FEW_SHOT);
  assign watchdog_hit = (few_shot_timeout != '0) &
                        (timer == few_shot_timeout - TIMEOUT_WIDTH'(1));

  assign enter_run      = (state_q == IDLE) & toggle_processing_new;
  assign enter_few_shot = (state_q == RUNNING) & ~start_sending & start_few_shot_processing;

  // ---------------------------------------------------------------------------
  // Next-state and next-remaining logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first. Without
  // the defaults, a missed branch would infer a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining;
    unique case (state_q)
      IDLE: begin
        if (toggle_processing_new) begin
          state_d = RUNNING;
        end
      end
      RUNNING: begin
        if (start_sending) begin
          state_d     = SENDING;
          remaining_d = (num_output_words == '0) ? OUT_WORDS_WIDTH'(1)
                                                 : num_output_words;
        end else if (start_few_shot_processing) begin
          state_d = PROCESSING_FEW_SHOT;
        end else if (toggle_processing_new | skip_sending) begin
          state_d = IDLE;
        end
      end
      SENDING: begin
        if (beat) begin
          remaining_d = remaining - OUT_WORDS_WIDTH'(1);
          if (remaining == OUT_WORDS_WIDTH'(1)) begin
            state_d = (want_restart & ~stop_req & below_limit) ? RUNNING : IDLE;
          end
        end
      end
      PROCESSING_FEW_SHOT: begin
        // A done in the same cycle as watchdog expiry takes priority.
        if (done_few_shot_processing | watchdog_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, down-counter, flags and registered handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: out_valid and out_last are loaded from the next-state values. They
  // then change on the same edge as state, and both outputs come straight
  // from flops with no decode logic after them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining    <= '0;
      stop_pending <= 1'b0;
      timed_out    <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      state_q   <= state_d;
      remaining <= remaining_d;
      out_valid <= (state_d == SENDING);
      out_last  <= (state_d == SENDING) & (remaining_d == OUT_WORDS_WIDTH'(1));

      if (enter_run | send_done) begin
        stop_pending <= 1'b0;
      end else if ((state_q == SENDING) & toggle_processing_new) begin
        stop_pending <= 1'b1;
      end

      if (enter_run) begin
        timed_out <= 1'b0;
      end else if (in_few_shot & ~done_few_shot_processing & watchdog_hit) begin
        timed_out <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Counters
  // ---------------------------------------------------------------------------
  inference_ctrl_fsm_sat_counter #(
    .WIDTH (INFER_COUNT_WIDTH)
  ) u_inference_counter (
    .clk    (clk),
    .rst    (rst),
    .clear  (enter_run),
    .enable (send_done),
    .count  (inference_count)
  );

  // The timer is 0 in the first cycle of PROCESSING_FEW_SHOT. A compare
  // against limit-1 therefore leaves the state after exactly `limit` cycles.
  inference_ctrl_fsm_sat_counter #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_watchdog_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (enter_few_shot),
    .enable (in_few_shot),
    .count  (timer)
  );

endmodule : inference_ctrl_fsm

// File: tb/tb_inference_ctrl_fsm.sv
module tb_inference_ctrl_fsm;
  import inference_ctrl_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        continuous_processing;
  logic        classification;
  logic        is_output_layer;
  logic        toggle_processing_new;
  logic        start_sending;
  logic        skip_sending;
  logic [7:0]  num_output_words;
  logic        out_ready;
  logic        out_valid;
  logic        out_last;
  logic        start_few_shot_processing;
  logic        done_few_shot_processing;
  logic [15:0] few_shot_timeout;
  logic [15:0] num_inferences;
  logic [15:0] inference_count;
  logic        timed_out;
  logic [STATE_BIT_WIDTH-1:0] state;
  logic [STATE_BIT_WIDTH-1:0] next_state;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       last;
    logic [7:0] idx;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;

  inference_ctrl_fsm dut (
    .clk                       (clk),
    .rst                       (rst),
    .continuous_processing     (continuous_processing),
    .classification            (classification),
    .is_output_layer           (is_output_layer),
    .toggle_processing_new     (toggle_processing_new),
    .start_sending             (start_sending),
    .skip_sending              (skip_sending),
    .num_output_words          (num_output_words),
    .out_ready                 (out_ready),
    .out_valid                 (out_valid),
    .out_last                  (out_last),
    .start_few_shot_processing (start_few_shot_processing),
    .done_few_shot_processing  (done_few_shot_processing),
    .few_shot_timeout          (few_shot_timeout),
    .num_inferences            (num_inferences),
    .inference_count           (inference_count),
    .timed_out                 (timed_out),
    .state                     (state),
    .next_state                (next_state)
  );

  always #5 clk = ~clk;

  // Beat monitor: it samples on the falling edge, well away from the rising
  // edge at which the inputs are driven.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL beat_unexpected: got a beat with out_last=%0b, required no beat", out_last);
      end else begin
        mon_e = sb.pop_front();
        if (out_last !== mon_e.last) begin
          miscompares++;
          $display("FAIL beat_out_last[%0d]: got %0b, required %0b", mon_e.idx, out_last, mon_e.last);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_run(input string tag);
    toggle_processing_new = 1'b1;
    tick();
    toggle_processing_new = 1'b0;
    vectors++;
    if (state !== RUNNING) begin
      miscompares++;
      $display("FAIL %s_start_state: got %0d, required %0d", tag, state, RUNNING);
    end
    vectors++;
    if (inference_count !== 16'd0) begin
      miscompares++;
      $display("FAIL %s_start_count: got %0d, required 0", tag, inference_count);
    end
    vectors++;
    if (timed_out !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_start_timed_out: got %0b, required 0", tag, timed_out);
    end
  endtask

  // Runs one send of n words (0 means 1 word). out_ready is held low during
  // [stall_after, stall_after+stall_len); toggle is pulsed at cycle toggle_at.
  task automatic do_send(input int n, input int stall_after, input int stall_len,
                         input int toggle_at, input string tag);
    int words;
    int beats;
    int cycles;
    words = (n == 0) ? 1 : n;
    for (int i = 0; i < words; i++) begin
      beat_t e;
      e.last = (i == words - 1);
      e.idx  = 8'(i);
      sb.push_back(e);
    end
    num_output_words = 8'(n);
    start_sending    = 1'b1;
    out_ready        = 1'b1;
    tick();
    start_sending = 1'b0;
    beats  = 0;
    cycles = 0;
    while (beats < words && cycles < words + stall_len + 20) begin
      out_ready = !(stall_after >= 0 && cycles >= stall_after && cycles < stall_after + stall_len);
      toggle_processing_new = (cycles == toggle_at);
      vectors++;
      if (out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_valid_held[c%0d]: got %0b, required 1", tag, cycles, out_valid);
      end
      if (out_valid && out_ready) beats++;
      tick();
      cycles++;
    end
    toggle_processing_new = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (cycles != words + stall_len) begin
      miscompares++;
      $display("FAIL %s_send_cycles: got %0d, required %0d", tag, cycles, words + stall_len);
    end
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_valid_falls: got %0b, required 0", tag, out_valid);
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_beats_missing: got %0d undelivered, required 0", tag, sb.size());
    end
  endtask

  task automatic check_end(input string tag, input logic [STATE_BIT_WIDTH-1:0] exp_state,
                           input logic [15:0] exp_count);
    vectors++;
    if (state !== exp_state) begin
      miscompares++;
      $display("FAIL %s_state: got %0d, required %0d", tag, state, exp_state);
    end
    vectors++;
    if (inference_count !== exp_count) begin
      miscompares++;
      $display("FAIL %s_count: got %0d, required %0d", tag, inference_count, exp_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if (state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_state: got %0d, required %0d", state, IDLE);
    end
    vectors++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: got valid=%0b last=%0b, required 0/0", out_valid, out_last);
    end
    vectors++;
    if (inference_count !== 16'd0 || timed_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got count=%0d timed_out=%0b, required 0/0", inference_count, timed_out);
    end
  endtask

  task automatic test_single_send();
    continuous_processing = 1'b0;
    classification        = 1'b1;
    is_output_layer       = 1'b1;
    start_run("single");
    do_send(3, 1, 2, -1, "single");
    check_end("single", IDLE, 16'd1);
  endtask

  task automatic test_bounded_continuous();
    continuous_processing = 1'b1;
    num_inferences        = 16'd2;
    start_run("bounded");
    do_send(1, -1, 0, -1, "bounded1");
    check_end("bounded1", RUNNING, 16'd1);
    do_send(1, -1, 0, -1, "bounded2");
    check_end("bounded2", IDLE, 16'd2);
    num_inferences = 16'd0;
  endtask

  task automatic test_stop_during_send();
    continuous_processing = 1'b1;
    start_run("stop");
    do_send(4, -1, 0, 1, "stop");
    check_end("stop", IDLE, 16'd1);
    // A restart clears the count. The output-layer path keeps running even
    // when continuous mode is off.
    continuous_processing = 1'b0;
    classification        = 1'b0;
    is_output_layer       = 1'b1;
    start_run("restart");
    do_send(2, -1, 0, -1, "restart");
    check_end("restart", RUNNING, 16'd1);
    toggle_processing_new = 1'b1;
    tick();
    toggle_processing_new = 1'b0;
    check_end("restart_stop", IDLE, 16'd1);
    classification = 1'b1;
  endtask

  task automatic test_watchdog();
    int cycles;
    for (int pass = 0; pass < 2; pass++) begin
      start_run(pass == 0 ? "wd_expire" : "wd_done");
      few_shot_timeout          = 16'd5;
      start_few_shot_processing = 1'b1;
      tick();
      start_few_shot_processing = 1'b0;
      vectors++;
      if (state !== PROCESSING_FEW_SHOT) begin
        miscompares++;
        $display("FAIL wd%0d_enter: got %0d, required %0d", pass, state, PROCESSING_FEW_SHOT);
      end
      cycles = 0;
      while (state == PROCESSING_FEW_SHOT && cycles < 50) begin
        toggle_processing_new    = (cycles == 1);
        done_few_shot_processing = (pass == 1) && (cycles == 4);
        if (cycles == 4) begin
          vectors++;
          if (next_state !== IDLE) begin
            miscompares++;
            $display("FAIL wd%0d_next_state: got %0d, required %0d", pass, next_state, IDLE);
          end
        end
        tick();
        cycles++;
      end
      toggle_processing_new    = 1'b0;
      done_few_shot_processing = 1'b0;
      vectors++;
      if (cycles != 5) begin
        miscompares++;
        $display("FAIL wd%0d_cycles: got %0d, required 5", pass, cycles);
      end
      vectors++;
      if (state !== IDLE) begin
        miscompares++;
        $display("FAIL wd%0d_state: got %0d, required %0d", pass, state, IDLE);
      end
      vectors++;
      if (timed_out !== (pass == 0)) begin
        miscompares++;
        $display("FAIL wd%0d_timed_out: got %0b, required %0b", pass, timed_out, pass == 0);
      end
    end
  endtask

  task automatic test_zero_word();
    continuous_processing = 1'b0;
    classification        = 1'b1;
    start_run("zero");
    do_send(0, -1, 0, -1, "zero");
    check_end("zero", IDLE, 16'd1);
  endtask

  task automatic test_skip_and_reset();
    start_run("skip");
    skip_sending = 1'b1;
    #1;
    vectors++;
    if (next_state !== IDLE) begin
      miscompares++;
      $display("FAIL skip_next_state: got %0d, required %0d", next_state, IDLE);
    end
    tick();
    skip_sending = 1'b0;
    check_end("skip", IDLE, 16'd0);

    start_run("rst_send");
    for (int i = 0; i < 4; i++) begin
      beat_t e;
      e.last = (i == 3);
      e.idx  = 8'(i);
      sb.push_back(e);
    end
    num_output_words = 8'd4;
    start_sending    = 1'b1;
    out_ready        = 1'b1;
    tick();
    start_sending = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_send_valid: got %0b, required 0", out_valid);
    end
    vectors++;
    if (sb.size() != 3) begin
      miscompares++;
      $display("FAIL rst_send_beats: got %0d undelivered, required 3", sb.size());
    end
    sb.delete();
    check_end("rst_send", IDLE, 16'd0);
  endtask

  initial begin
    rst                       = 1'b1;
    continuous_processing     = 1'b0;
    classification            = 1'b1;
    is_output_layer           = 1'b0;
    toggle_processing_new     = 1'b0;
    start_sending             = 1'b0;
    skip_sending              = 1'b0;
    num_output_words          = 8'd0;
    out_ready                 = 1'b0;
    start_few_shot_processing = 1'b0;
    done_few_shot_processing  = 1'b0;
    few_shot_timeout          = 16'd0;
    num_inferences            = 16'd0;

    test_reset();
    test_single_send();
    test_bounded_continuous();
    test_stop_during_send();
    test_watchdog();
    test_zero_word();
    test_skip_and_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_inference_ctrl_fsm

// File: doc/inference_ctrl_fsm.md
# inference_ctrl_fsm

Parametrised successor of the top-level processing controller. Sequences IDLE → RUNNING → SENDING / PROCESSING_FEW_SHOT, and adds three things:
- a built-in output-word handshake with beat counting, replacing the external `done_sending` pulse;
- a bounded inference count for continuous mode;
- a watchdog timeout on few-shot processing.

It sits between the host/SPI command decoder and the network datapath, and drives the state bus consumed by the datapath and output serializer.

## Interface
- `OUT_WORDS_WIDTH`, 8: width of the per-inference output word count.
- `INFER_COUNT_WIDTH`, 16: width of the inference limit and inference counter.
- `TIMEOUT_WIDTH`, 16: width of the few-shot watchdog limit and timer.
- `STATE_BIT_WIDTH`, derived: `$clog2(NUMBER_OF_STATES)` from the shared states header; not overridable.

- `clk` in 1: clock. Single clock; reset is synchronous and active-high (`rst`).
- `rst` in 1: synchronous active-high reset.
- `continuous_processing` in 1: restart after each send.
- `classification` in 1: classification mode.
- `is_output_layer` in 1: current layer is the output layer.
- `toggle_processing_new` in 1: start (in IDLE) or stop request.
- `start_sending` in 1: results ready to send.
- `skip_sending` in 1: finish the inference without sending.
- `num_output_words` in `OUT_WORDS_WIDTH`: words to send; latched at `start_sending`.
- `out_ready` in 1: output sink ready.
- `out_valid` out 1: current output word valid.
- `out_last` out 1: current word is the final word of the send.
- `start_few_shot_processing` in 1: enter few-shot learning.
- `done_few_shot_processing` in 1: few-shot learning complete.
- `few_shot_timeout` in `TIMEOUT_WIDTH`: watchdog limit in cycles; 0 disables the watchdog.
- `num_inferences` in `INFER_COUNT_WIDTH`: continuous-mode inference limit; 0 means unlimited.
- `inference_count` out `INFER_COUNT_WIDTH`: completed sends since the last start.
- `timed_out` out 1: sticky flag; last few-shot phase was aborted by the watchdog.
- `state` out `STATE_BIT_WIDTH`: registered state.
- `next_state` out `STATE_BIT_WIDTH`: combinational next state.

## Operation
States: `IDLE`, `RUNNING`, `SENDING`, `PROCESSING_FEW_SHOT`. Encodings come from the shared header. Any unencoded state returns to `IDLE`.

**IDLE**
- `toggle_processing_new` → RUNNING.
- Entering RUNNING from IDLE clears `inference_count`, `timed_out` and `stop_pending`.

**RUNNING** (priority order)
- `start_sending` → SENDING. Latch `remaining = num_output_words`; a value of 0 is loaded as 1.
- else `start_few_shot_processing` → PROCESSING_FEW_SHOT. Clear the watchdog timer.
- else `toggle_processing_new | skip_sending` → IDLE.
- else stay in RUNNING.

**SENDING**
- `out_valid = (state == SENDING)`; `out_last = out_valid & (remaining == 1)`.
- Each cycle with `out_valid & out_ready` is a beat and decrements `remaining`.
- `toggle_processing_new` while in SENDING sets `stop_pending`. The send still completes, so no words are dropped.
- On the beat where `out_last` is high (send completion):
  - `inference_count` increments, saturating at all-ones.
  - Transition to RUNNING iff all three hold: `continuous_processing | (~classification & is_output_layer)`, `~stop_pending`, and (`num_inferences == 0` or `inference_count + 1 < num_inferences`).
  - Otherwise → IDLE.
  - `stop_pending` clears in both cases.

**PROCESSING_FEW_SHOT**
- Timer increments every cycle spent in this state.
- `done_few_shot_processing` → IDLE.
- else, if `few_shot_timeout != 0` and `timer == few_shot_timeout - 1` → IDLE and set `timed_out`.
- `done_few_shot_processing` and watchdog expiry in the same cycle: done wins, `timed_out` stays 0.
- `toggle_processing_new` is ignored in this state.

**Width rules**
- `inference_count + 1` is compared at `INFER_COUNT_WIDTH + 1` bits, so there is no wrap.
- The watchdog timer is `TIMEOUT_WIDTH` bits and cannot wrap before its compare fires.

## Timing
- `state` updates on the `clk` edge after the inputs are sampled; `next_state` reflects the current inputs combinationally.
- Reset values:
  - `state` = IDLE
  - `remaining`, `inference_count`, timer = 0
  - `timed_out`, `stop_pending` = 0
  - `out_valid` = `out_last` = 0
- Reset mid-send drops the transfer immediately; `out_valid` is low in the first cycle after reset.
- Handshake rules:
  - `out_valid` rises in the first cycle in SENDING.
  - `out_valid` stays high until the final beat and never drops while `out_ready` is low.
  - `out_valid` falls in the cycle after the final beat.
- Minimum send of N words with `out_ready` held high: N cycles in SENDING.
- Watchdog with limit T and no done: exactly T cycles in PROCESSING_FEW_SHOT.

## Structure
- The shared `states.vh` holds the state encodings and `NUMBER_OF_STATES`, unchanged for the existing four states.
- One natural sub-module: `sat_counter` (parametrised width, clear, enable, saturating). Instantiate it for `inference_count` and the watchdog timer.
- The remaining logic (next-state case statement, `remaining` down-counter, flags) stays in this module.

## Test plan
- **Single send, not continuous.** Reset, toggle, `start_sending` with `num_output_words=3`, `out_ready` stalled low 2 cycles mid-send. Expect exactly 3 beats with `out_last` on the 3rd, `out_valid` held through the stall, then IDLE and `inference_count=1`.
- **Bounded continuous run.** `continuous_processing=1`, `num_inferences=2`, two sends of 1 word. Expect RUNNING after the first send, IDLE after the second, `inference_count=2`.
- **Stop during send.** Continuous mode, toggle pulsed during a 4-word send. Expect all 4 beats delivered, then IDLE; the next toggle restarts with `inference_count` cleared.
- **Watchdog expiry.** Few-shot with `few_shot_timeout=5` and no done. Expect IDLE after exactly 5 cycles with `timed_out=1`. With done asserted on the 5th cycle, expect `timed_out=0`.
- **Zero-word send.** `num_output_words=0`. Expect one beat with `out_last=1`.
- **Skip and reset mid-send.** `skip_sending` in RUNNING → IDLE next cycle. Reset during a send → `out_valid=0` and IDLE in the next cycle.
